// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Types and constants shared by the RV32I pipeline stages.
//   XLEN              : architectural register / address width
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   INSTR_NOP         : canonical ADDI x0,x0,0 encoding
//   fetch_state_e     : fetch-stage control states
//   fetch_entry_t     : one decoded-stage entry, {pc, instruction word}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO with registered output (no push-to-pop bypass).
//   Ports:
//     clk_i, rst_i  : clock, asynchronous active-high reset (control only)
//     push_i        : write wdata_i at the tail
//     pop_i         : drop the head entry
//     flush_i       : empty the FIFO; overrides push and pop
//     wdata_i       : entry to write
//     rdata_o       : current head entry (meaningful when !empty_o)
//     count_o       : number of stored entries
//     full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  T              wdata_i,
    output T              rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO lands only when the head is popped the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   RV32I instruction-fetch stage. Owns the PC, issues word fetches to
//   instruction memory under a credit limit, buffers in-order responses and
//   hands {pc, pc+4, instruction} to decode with a valid/ready handshake.
//   Execute redirects the stream on taken branches and jumps.
//   Ports:
//     clk, rst                        : clock, asynchronous active-high reset
//     imem_req_valid/ready/addr       : fetch request channel (word address)
//     imem_rsp_valid/data             : in-order response channel, no backpressure
//     redirect_valid/pc               : redirect from execute (pc[1:0] ignored)
//     dec_valid/ready                 : decode handshake
//     dec_pc/pc_plus4/instruction     : decode payload
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
    output logic [XLEN-1:0] dec_instruction
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   rsp_remaining;
    logic [CW:0]     credits_used;
    logic            req_fire;

    fetch_entry_t    ibuf_wdata, ibuf_head;
    logic            ibuf_push, ibuf_pop;
    logic            ibuf_full, ibuf_empty;
    logic [CW-1:0]   ibuf_count;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_full, pcq_empty;
    logic [CW-1:0]   pcq_count;

    // Requests in flight plus buffered entries never exceed the buffer depth,
    // so every response that comes back is guaranteed a slot.
    assign credits_used   = {1'b0, outstanding_q} + {1'b0, ibuf_count};
    assign imem_req_valid = (state_q == FETCH_RUN) && !redirect_valid
                            && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = imem_req_valid ? pc_q : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Requests still owed a response once this cycle's response is counted.
    assign rsp_remaining  = outstanding_q - CW'(imem_rsp_valid);

    // Responses to requests made before a redirect are counted off by drop_cnt.
    assign ibuf_push  = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign ibuf_pop   = dec_valid && dec_ready;
    assign ibuf_wdata = '{pc: pcq_head, instr: imem_rsp_data};

    assign dec_valid       = !ibuf_empty && !redirect_valid;
    assign dec_pc          = ibuf_empty ? '0 : ibuf_head.pc;
    assign dec_pc_plus4    = ibuf_empty ? '0 : ibuf_head.pc + XLEN'(4);
    assign dec_instruction = ibuf_empty ? '0 : ibuf_head.instr;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = rsp_remaining + CW'(req_fire);
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~XLEN'(3);
            drop_cnt_d = rsp_remaining;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redirect_valid && (rsp_remaining != '0)) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                // A redirect while draining reloads the PC but keeps draining.
                if (!redirect_valid && (drop_cnt_d == '0)) begin
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_ibuf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (ibuf_push),
        .pop_i   (ibuf_pop),
        .flush_i (redirect_valid),
        .wdata_i (ibuf_wdata),
        .rdata_o (ibuf_head),
        .count_o (ibuf_count),
        .full_o  (ibuf_full),
        .empty_o (ibuf_empty)
    );

    // PC of every accepted request, consumed in order by the responses.
    // Not flushed on redirect: stale responses still retire their entries.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pcq (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (req_fire),
        .pop_i   (imem_rsp_valid),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    a_rsp_needs_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));

    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ibuf_push |-> (!ibuf_full || ibuf_pop));

    a_dec_stable: assert property (@(posedge clk) disable iff (rst)
        (dec_valid && !dec_ready) |=> (!dec_valid || ($stable(dec_pc)
            && $stable(dec_pc_plus4) && $stable(dec_instruction))));

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        imem_req_addr[1:0] == 2'b00);

    a_pcq_tracks: assert property (@(posedge clk) disable iff (rst)
        (pcq_count == outstanding_q) && !(imem_rsp_valid && pcq_empty)
        && !(req_fire && pcq_full && !imem_rsp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = RESET_PC_DEFAULT;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic [31:0] dec_instruction;

    fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_pc_plus4    (dec_pc_plus4),
        .dec_instruction (dec_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instruction memory image ----------------
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a[5:2] == 4'hF) return INSTR_NOP;
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h0000_1013;
    endfunction

    typedef struct {
        int          t;
        logic [31:0] d;
    } rsp_t;
    rsp_t pend[$];
    int   last_t;
    int   cyc = 0;
    int   n_fire;

    // ---------------- behavioural model state ----------------
    bit           m_boot;
    bit           m_drain;
    logic [31:0]  m_pc;
    int           m_out;
    int           m_drop;
    logic [31:0]  m_infl[$];
    fetch_entry_t m_buf[$];
    logic [31:0]  xfer[$];
    int           xfer_cyc[$];
    logic [31:0]  d_p4[$];

    // ---------------- stimulus knobs ----------------
    int unsigned p_req_ready, p_dec_ready, p_redir, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] xget(input int i);
        return (i < xfer.size()) ? xfer[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 4095));
    endfunction

    task automatic model_reset();
        m_boot  = 1'b1;
        m_drain = 1'b0;
        m_pc    = RPC;
        m_out   = 0;
        m_drop  = 0;
        m_infl.delete();
        m_buf.delete();
        pend.delete();
        last_t  = -1;
    endtask

    task automatic do_reset(input int hold);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_pc_plus4", dec_pc_plus4, 32'd0);
        chk("rst_dec_instr", dec_instruction, 32'd0);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance both.
    task automatic step();
        logic        redir, rr, dr, rsp;
        logic [31:0] rpc, rdata, pcr;
        bit          e_req, e_dec, fire, pop;
        int          tr;

        redir = force_redir || (!m_boot && ($urandom_range(0, 99) < p_redir));
        rpc   = force_redir ? force_rpc : rand_target();
        rr    = ($urandom_range(0, 99) < p_req_ready);
        dr    = ($urandom_range(0, 99) < p_dec_ready);
        rsp   = (pend.size() > 0) && (pend[0].t <= cyc);
        rdata = rsp ? pend[0].d : $urandom();

        imem_req_ready = rr;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = dr;

        @(negedge clk);
        e_req = !m_boot && !m_drain && !redir && ((m_out + m_buf.size()) < DEPTH);
        e_dec = (m_buf.size() > 0) && !redir;
        chk("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) chk("req_addr", imem_req_addr, m_pc);
        chk("dec_valid", 32'(dec_valid), 32'(e_dec));
        if (e_dec) begin
            chk("dec_pc", dec_pc, m_buf[0].pc);
            chk("dec_pc_plus4", dec_pc_plus4, m_buf[0].pc + 32'd4);
            chk("dec_instr", dec_instruction, m_buf[0].instr);
        end

        // memory answers whatever the DUT actually handshook
        if (imem_req_valid && rr) begin
            n_fire++;
            tr = cyc + int'($urandom_range(lat_min, lat_max));
            if (tr <= last_t) tr = last_t + 1;
            pend.push_back('{t: tr, d: memf(imem_req_addr)});
            last_t = tr;
        end
        if (rsp) void'(pend.pop_front());

        fire = e_req && rr;
        pop  = e_dec && dr;
        if (pop) begin
            xfer.push_back(m_buf[0].pc);
            xfer_cyc.push_back(cyc);
        end
        if (dec_valid && dr) d_p4.push_back(dec_pc_plus4);

        pcr = '0;
        if (rsp) begin
            if (m_infl.size() > 0) pcr = m_infl.pop_front();
            m_out--;
        end
        if (redir) begin
            m_buf.delete();
            m_drop = m_out;
            m_pc   = rpc & ~32'd3;
            if (!m_boot) m_drain = m_drain || (m_out > 0);
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else m_buf.push_back('{pc: pcr, instr: rdata});
            end
            if (fire) begin
                m_infl.push_back(m_pc);
                m_out++;
                m_pc = m_pc + 32'd4;
            end
            if (m_drain && (m_drop == 0)) m_drain = 1'b0;
        end
        m_boot = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_knobs(input int unsigned rr, input int unsigned dr, input int unsigned rd,
                             input int unsigned lmin, input int unsigned lmax);
        p_req_ready = rr;
        p_dec_ready = dr;
        p_redir     = rd;
        lat_min     = lmin;
        lat_max     = lmax;
    endtask

    task automatic clear_logs();
        xfer.delete();
        xfer_cyc.delete();
        d_p4.delete();
        n_fire = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int c0;
        rst         = 1'b1;
        force_redir = 1'b0;
        force_rpc   = '0;
        set_knobs(100, 100, 0, 1, 1);

        // 1: straight-line fetch
        do_reset(2);
        clear_logs();
        c0 = cyc;
        repeat (20) step();
        chk("t1_first_xfer_cycle", 32'(xfer_cyc.size() > 0 ? xfer_cyc[0] - c0 : -1), 32'd3);
        chk("t1_pc0", xget(0), 32'h0);
        chk("t1_pc1", xget(1), 32'h4);
        chk("t1_pc2", xget(2), 32'h8);

        // 2: decode stalled for a while, then released
        do_reset(2);
        clear_logs();
        set_knobs(100, 0, 0, 1, 1);
        repeat (12) step();
        chk("t2_stall_fires", 32'(n_fire), 32'(DEPTH));
        chk("t2_stall_no_xfer", 32'(xfer.size()), 32'd0);
        set_knobs(100, 100, 0, 1, 1);
        repeat (20) step();
        chk("t2_pc0", xget(0), 32'h0);
        chk("t2_pc1", xget(1), 32'h4);
        chk("t2_pc2", xget(2), 32'h8);
        chk("t2_pc3", xget(3), 32'hC);

        // 3: redirect with two requests outstanding (latency 3)
        do_reset(2);
        clear_logs();
        set_knobs(100, 100, 0, 3, 3);
        repeat (3) step();
        chk("t3_inflight", 32'(n_fire), 32'd2);
        force_redir = 1'b1;
        force_rpc   = 32'h0000_0100;
        step();
        force_redir = 1'b0;
        chk("t3_no_xfer_before", 32'(xfer.size()), 32'd0);
        repeat (20) step();
        chk("t3_pc0", xget(0), 32'h100);
        chk("t3_pc1", xget(1), 32'h104);

        // 4: redirect coinciding with a response and a ready decode
        do_reset(2);
        clear_logs();
        set_knobs(100, 100, 0, 1, 1);
        repeat (3) step();
        force_redir = 1'b1;
        force_rpc   = 32'h0000_0202;
        step();
        force_redir = 1'b0;
        chk("t4_no_xfer_at_redirect", 32'(xfer.size()), 32'd0);
        repeat (15) step();
        chk("t4_pc0", xget(0), 32'h200);
        chk("t4_pc1", xget(1), 32'h204);

        // 5: redirect to the top of the address space
        clear_logs();
        force_redir = 1'b1;
        force_rpc   = 32'hFFFF_FFFC;
        step();
        force_redir = 1'b0;
        repeat (15) step();
        chk("t5_pc0", xget(0), 32'hFFFF_FFFC);
        chk("t5_p4_0", d_p4.size() > 0 ? d_p4[0] : 32'hDEAD_BEEF, 32'h0);
        chk("t5_pc1", xget(1), 32'h0);

        // 6: reset in the middle of traffic
        set_knobs(100, 50, 0, 3, 3);
        repeat (6) step();
        do_reset(2);
        clear_logs();
        set_knobs(100, 100, 0, 1, 2);
        repeat (15) step();
        chk("t6_pc0", xget(0), RPC);
        chk("t6_pc1", xget(1), RPC + 32'd4);

        // randomized traffic
        for (int seg = 0; seg < 10; seg++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 8), 1, 1);
            lat_min = $urandom_range(1, 2);
            lat_max = lat_min + $urandom_range(0, 3);
            repeat (300) step();
            if ((seg % 3) == 2) do_reset(1 + (seg % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
